// File: rtl/conv_pkg.sv
// Shared definitions for the convolution engine controller: register map,
// STATUS bit positions, FSM state encoding and the saturation helper.
package conv_pkg;

  // Slave register word indices
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_IN_BASE  = 3'd1;
  localparam logic [2:0] REG_W_BASE   = 3'd2;
  localparam logic [2:0] REG_OUT_BASE = 3'd3;
  localparam logic [2:0] REG_L        = 3'd4;
  localparam logic [2:0] REG_F        = 3'd5;
  localparam logic [2:0] REG_N        = 3'd6;
  localparam logic [2:0] REG_STATUS   = 3'd7;

  // STATUS bit positions
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  // Width used by the saturation helper; accumulators up to this width are supported
  localparam int SAT_W = 64;

  // Kernel row/column counter width (kernel edge is at most 7)
  localparam int KW = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    FETCH,
    RMW_RD,
    WRITE,
    DONE
  } state_t;

  // Clamp a signed value to the signed range of a dw-bit word
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                  input int dw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// K*K weight buffer plus signed multiply-accumulate datapath.
// The accumulator is either loaded with the first product of a window
// (mac_clr) or summed; add_en folds in a previously stored partial sum.
module conv_mac
  import conv_pkg::*;
#(
  parameter int KSIZE  = 3,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int TAP_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TAP_W-1:0]  tap,
  input  logic              wt_we,
  input  logic [DATA_W-1:0] wt_data,
  input  logic              mac_en,
  input  logic              mac_clr,
  input  logic [DATA_W-1:0] pix,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_data,
  output logic [DATA_W-1:0] sat_out
);

  logic signed [DATA_W-1:0]   wbuf [KSIZE*KSIZE];
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;

  // Weight buffer: always reloaded before use, so it needs no reset
  always_ff @(posedge clk) begin
    if (wt_we) wbuf[tap] <= wt_data;
  end

  // Full-precision signed product of the selected weight and the pixel
  always_comb begin
    prod = wbuf[tap] * $signed(pix);
  end

  // Accumulator: load on first tap, sum on later taps, add stored partial sum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (mac_en) begin
      acc <= mac_clr ? ACC_W'(prod) : acc + ACC_W'(prod);
    end else if (add_en) begin
      acc <= acc + ACC_W'($signed(add_data));
    end
  end

  // Saturated view of the accumulator
  always_comb begin
    sat_out = DATA_W'(sat(SAT_W'(acc), DATA_W));
  end

endmodule

// File: rtl/conv_engine_ctrl.sv
// Avalon-MM convolution engine controller: slave register file, sequencing
// FSM, loop counters and SDRAM address generation. The master port holds a
// request (read/write with address/data) until the cycle waitrequest is low;
// that cycle is the transfer, readdata is consumed in it, and a new request
// may follow in the next cycle. At most one request is ever outstanding.
// Optional macro CONV_RELU_EN: clamp final-layer outputs at zero.
module conv_engine_ctrl
  import conv_pkg::*;
#(
  parameter int KSIZE  = 3,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  output logic              slave_waitrequest,
  output logic [31:0]       master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata,
  input  logic              master_waitrequest,
  output logic              irq
);

  localparam int KK    = KSIZE * KSIZE;
  localparam int TAP_W = (KK > 1) ? $clog2(KK) : 1;

  state_t            state, state_nxt;
  logic [31:0]       in_base, w_base, out_base;
  logic [DIM_W-1:0]  l_reg, f_reg, n_reg;
  logic              done_flag, busy, start, cfg_ok;
  logic [DIM_W-1:0]  f_cnt, l_cnt, r_cnt, c_cnt, o_dim;
  logic [KW-1:0]     kr, kc;
  logic [TAP_W-1:0]  tap;
  logic              last_tap, last_col, last_row, last_layer, last_filt;
  logic [31:0]       w_addr, in_addr, out_addr, word_addr;
  logic              wt_we, mac_en, mac_clr, add_en;
  logic [DATA_W-1:0] sat_out, wr_data;

  assign slave_waitrequest = 1'b0;
  assign irq               = done_flag;
  assign master_address    = {word_addr[29:0], 2'b00};

  // Loop bookkeeping and address generation
  always_comb begin
    busy       = (state == LOAD_W) || (state == FETCH) || (state == RMW_RD) || (state == WRITE);
    start      = slave_write && (slave_address == REG_CTRL) && (state == IDLE);
    cfg_ok     = (n_reg >= DIM_W'(KSIZE)) && (l_reg != '0) && (f_reg != '0);
    o_dim      = n_reg - DIM_W'(KSIZE) + DIM_W'(1);
    tap        = TAP_W'(32'(kr) * KSIZE + 32'(kc));
    last_tap   = (kr == KW'(KSIZE - 1)) && (kc == KW'(KSIZE - 1));
    last_col   = (c_cnt == o_dim - DIM_W'(1));
    last_row   = (r_cnt == o_dim - DIM_W'(1));
    last_layer = (l_cnt == l_reg - DIM_W'(1));
    last_filt  = (f_cnt == f_reg - DIM_W'(1));
    w_addr     = w_base + (32'(f_cnt) * 32'(l_reg) + 32'(l_cnt)) * KK + 32'(tap);
    in_addr    = in_base + 32'(l_cnt) * 32'(n_reg) * 32'(n_reg)
               + (32'(r_cnt) + 32'(kr)) * 32'(n_reg) + 32'(c_cnt) + 32'(kc);
    out_addr   = out_base + 32'(f_cnt) * 32'(o_dim) * 32'(o_dim)
               + 32'(r_cnt) * 32'(o_dim) + 32'(c_cnt);
  end

  // Output value: raw saturated sum, optionally clamped at zero on the final layer
  always_comb begin
    wr_data = sat_out;
`ifdef CONV_RELU_EN
    if (last_layer && sat_out[DATA_W-1]) wr_data = '0;
`else
`endif
  end

  // Register file and sticky DONE flag; DONE set beats a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_base   <= '0;
      w_base    <= '0;
      out_base  <= '0;
      l_reg     <= '0;
      f_reg     <= '0;
      n_reg     <= '0;
      done_flag <= 1'b0;
    end else begin
      if (slave_write && !busy) begin
        case (slave_address)
          REG_IN_BASE:  in_base  <= slave_writedata;
          REG_W_BASE:   w_base   <= slave_writedata;
          REG_OUT_BASE: out_base <= slave_writedata;
          REG_L:        l_reg    <= slave_writedata[DIM_W-1:0];
          REG_F:        f_reg    <= slave_writedata[DIM_W-1:0];
          REG_N:        n_reg    <= slave_writedata[DIM_W-1:0];
          default:      ;
        endcase
      end
      if (state == DONE) done_flag <= 1'b1;
      else if (slave_write && (slave_address == REG_STATUS) && slave_writedata[STATUS_DONE])
        done_flag <= 1'b0;
    end
  end

  // Register readback, valid while slave_read is asserted
  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        REG_IN_BASE:  slave_readdata = in_base;
        REG_W_BASE:   slave_readdata = w_base;
        REG_OUT_BASE: slave_readdata = out_base;
        REG_L:        slave_readdata = 32'(l_reg);
        REG_F:        slave_readdata = 32'(f_reg);
        REG_N:        slave_readdata = 32'(n_reg);
        REG_STATUS: begin
          slave_readdata[STATUS_BUSY] = busy;
          slave_readdata[STATUS_DONE] = done_flag;
        end
        default:      slave_readdata = '0;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and master/datapath controls
  always_comb begin
    state_nxt        = state;
    master_read      = 1'b0;
    master_write     = 1'b0;
    master_writedata = '0;
    word_addr        = '0;
    wt_we            = 1'b0;
    mac_en           = 1'b0;
    mac_clr          = 1'b0;
    add_en           = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = cfg_ok ? LOAD_W : DONE;
      end
      LOAD_W: begin
        master_read = 1'b1;
        word_addr   = w_addr;
        wt_we       = !master_waitrequest;
        if (!master_waitrequest && last_tap) state_nxt = FETCH;
      end
      FETCH: begin
        master_read = 1'b1;
        word_addr   = in_addr;
        mac_en      = !master_waitrequest;
        mac_clr     = (kr == '0) && (kc == '0);
        if (!master_waitrequest && last_tap) state_nxt = (l_cnt != '0) ? RMW_RD : WRITE;
      end
      RMW_RD: begin
        master_read = 1'b1;
        word_addr   = out_addr;
        add_en      = !master_waitrequest;
        if (!master_waitrequest) state_nxt = WRITE;
      end
      WRITE: begin
        master_write     = 1'b1;
        word_addr        = out_addr;
        master_writedata = wr_data;
        if (!master_waitrequest) begin
          if (!(last_col && last_row))      state_nxt = FETCH;
          else if (!last_layer || !last_filt) state_nxt = LOAD_W;
          else                              state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Loop counters: kernel taps advance per transfer, pixels/layers/filters per write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_cnt <= '0; l_cnt <= '0; r_cnt <= '0; c_cnt <= '0; kr <= '0; kc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            f_cnt <= '0; l_cnt <= '0; r_cnt <= '0; c_cnt <= '0; kr <= '0; kc <= '0;
          end
        end
        LOAD_W, FETCH: begin
          if (!master_waitrequest) begin
            if (kc == KW'(KSIZE - 1)) begin
              kc <= '0;
              kr <= (kr == KW'(KSIZE - 1)) ? '0 : kr + KW'(1);
            end else begin
              kc <= kc + KW'(1);
            end
          end
        end
        WRITE: begin
          if (!master_waitrequest) begin
            if (!last_col) begin
              c_cnt <= c_cnt + DIM_W'(1);
            end else begin
              c_cnt <= '0;
              if (!last_row) begin
                r_cnt <= r_cnt + DIM_W'(1);
              end else begin
                r_cnt <= '0;
                if (!last_layer) begin
                  l_cnt <= l_cnt + DIM_W'(1);
                end else begin
                  l_cnt <= '0;
                  f_cnt <= f_cnt + DIM_W'(1);
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  conv_mac #(
    .KSIZE  (KSIZE),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .TAP_W  (TAP_W)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .tap      (tap),
    .wt_we    (wt_we),
    .wt_data  (master_readdata),
    .mac_en   (mac_en),
    .mac_clr  (mac_clr),
    .pix      (master_readdata),
    .add_en   (add_en),
    .add_data (master_readdata),
    .sat_out  (sat_out)
  );

endmodule
